// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB and decodes
// datapath controls from the state register, with a mem_ready handshake and timeout.
module mc_control_unit #(
    parameter int OPCODE_W    = 6,
    parameter int ALU_OP_W    = 2,
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 32
) (
    input  logic                clk,
    input  logic                arst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic [1:0]          pc_source,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                reg_dst,
    output logic                mem_2_reg,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                instr_done,
    output logic                illegal_op,
    output logic                mem_err,
    output logic [CNT_W-1:0]    instr_count
);

    localparam int WAIT_W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);

    localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'('h00);
    localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'('h02);
    localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'('h04);
    localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'('h08);
    localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'('h23);
    localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'('h2B);

    typedef enum logic [3:0] {
        S_RESET, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
        S_EXECUTE, S_R_WB, S_ADDI_EX, S_ADDI_WB, S_BRANCH, S_JUMP
    } state_t;

    state_t              state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                drain;
    logic                mem_state;
    logic                timeout;
    logic                legal_op;
    logic                retire;

    // drain marks the strobe-free FETCH cycle that follows an abandoned access
    assign mem_state = (state == S_FETCH && !drain) || state == S_MEM_READ || state == S_MEM_WRITE;
    assign timeout   = (TIMEOUT_CYC != 0) && mem_state && !mem_ready &&
                       (wait_cnt == WAIT_W'(TIMEOUT_CYC));
    assign legal_op  = (opcode == OP_R) || (opcode == OP_J) || (opcode == OP_BEQ) ||
                       (opcode == OP_ADDI) || (opcode == OP_LW) || (opcode == OP_SW);
    assign retire    = instr_done && (state != S_DECODE);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state       <= S_RESET;
            wait_cnt    <= '0;
            drain       <= 1'b0;
            instr_count <= '0;
        end else begin
            drain <= 1'b0;
            if (mem_state && !mem_ready && !timeout)
                wait_cnt <= wait_cnt + WAIT_W'(1);
            else
                wait_cnt <= '0;
            if (retire)
                instr_count <= instr_count + CNT_W'(1);

            if (timeout) begin
                state <= S_FETCH;
                drain <= 1'b1;
            end else begin
                case (state)
                    S_RESET:     state <= S_FETCH;
                    S_FETCH:     if (!drain && mem_ready) state <= S_DECODE;
                    S_DECODE: begin
                        case (opcode)
                            OP_R:         state <= S_EXECUTE;
                            OP_ADDI:      state <= S_ADDI_EX;
                            OP_BEQ:       state <= S_BRANCH;
                            OP_J:         state <= S_JUMP;
                            OP_LW, OP_SW: state <= S_MEM_ADDR;
                            default:      state <= S_FETCH;
                        endcase
                    end
                    S_MEM_ADDR:  state <= (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
                    S_MEM_READ:  if (mem_ready) state <= S_MEM_WB;
                    S_MEM_WRITE: if (mem_ready) state <= S_FETCH;
                    S_EXECUTE:   state <= S_R_WB;
                    S_ADDI_EX:   state <= S_ADDI_WB;
                    default:     state <= S_FETCH;
                endcase
            end
        end
    end

    // Moore decode; FETCH completion and MEM_WRITE retirement follow mem_ready
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_2_reg     = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = '0;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;
        mem_err       = timeout;
        case (state)
            S_FETCH: begin
                if (!drain) begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    pc_write  = mem_ready;
                    ir_write  = mem_ready;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                if (!legal_op) begin
                    illegal_op = 1'b1;
                    instr_done = 1'b1;
                end
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_2_reg  = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_OP_W'(2);
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDI_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_OP_W'(1);
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                instr_done    = 1'b1;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: per-instruction step model checked every cycle,
// plus literal expectations at the points of interest of each directed scenario.
module tb_mc_control_unit;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic [5:0]  opcode = 6'h00;
    logic        mem_ready = 1'b0;
    logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic        reg_dst, mem_2_reg, reg_write, alu_src_a, instr_done, illegal_op, mem_err;
    logic [1:0]  pc_source, alu_src_b, alu_op;
    logic [31:0] instr_count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       pc_write, pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_2_reg, reg_write, alu_src_a;
        logic [1:0] alu_src_b, alu_op;
        logic       instr_done, illegal_op, mem_err;
    } ctl_t;

    typedef enum int {K_FETCH, K_DEC, K_ADDR, K_RD, K_MWB, K_WR, K_EXE, K_RWB,
                      K_AEX, K_AWB, K_BR, K_J} kind_e;

    ctl_t act;
    assign act = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
                  reg_dst, mem_2_reg, reg_write, alu_src_a, alu_src_b, alu_op,
                  instr_done, illegal_op, mem_err};

    mc_control_unit #(.OPCODE_W(6), .ALU_OP_W(2), .TIMEOUT_CYC(TO), .CNT_W(32)) dut (
        .clk(clk), .arst(arst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_2_reg(mem_2_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .instr_done(instr_done), .illegal_op(illegal_op), .mem_err(mem_err),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // Zero-wait instruction lengths in cycles, FETCH included.
    function automatic int instr_len(input logic [5:0] op);
        case (op)
            6'h00, 6'h08, 6'h2B: return 4;
            6'h04, 6'h02:        return 3;
            6'h23:               return 5;
            default:             return 2;
        endcase
    endfunction

    function automatic kind_e step_kind(input logic [5:0] op, input int idx);
        if (idx == 0) return K_FETCH;
        if (idx == 1) return K_DEC;
        case (op)
            6'h00:   return (idx == 2) ? K_EXE : K_RWB;
            6'h08:   return (idx == 2) ? K_AEX : K_AWB;
            6'h04:   return K_BR;
            6'h02:   return K_J;
            6'h23:   return (idx == 2) ? K_ADDR : ((idx == 3) ? K_RD : K_MWB);
            6'h2B:   return (idx == 2) ? K_ADDR : K_WR;
            default: return K_DEC;
        endcase
    endfunction

    bit          m_boot = 1'b0;
    bit          m_drain = 1'b0;
    int          m_idx = 0;
    int          m_wait = 0;
    logic [5:0]  m_op = 6'h00;
    logic [31:0] m_count = 32'd0;

    always @(negedge clk) begin : model
        ctl_t        e;
        kind_e       k;
        bit          is_mem;
        logic [31:0] cnt_exp;
        e = '0;
        cnt_exp = m_count;
        if (arst) begin
            cnt_exp = 32'd0;
            m_boot = 1'b1; m_drain = 1'b0; m_idx = 0; m_wait = 0; m_count = 32'd0;
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_drain) begin
            m_drain = 1'b0;
        end else begin
            if (m_idx == 1) m_op = opcode;
            k = step_kind(m_op, m_idx);
            is_mem = (k == K_FETCH) || (k == K_RD) || (k == K_WR);
            case (k)
                K_FETCH: begin e.mem_read = 1; e.alu_src_b = 2'b01;
                               e.pc_write = mem_ready; e.ir_write = mem_ready; end
                K_DEC:   begin e.alu_src_b = 2'b11;
                               if (instr_len(m_op) == 2) e.illegal_op = 1; end
                K_ADDR:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
                K_RD:    begin e.mem_read = 1; e.i_or_d = 1; end
                K_MWB:   begin e.reg_write = 1; e.mem_2_reg = 1; end
                K_WR:    begin e.mem_write = 1; e.i_or_d = 1; end
                K_EXE:   begin e.alu_src_a = 1; e.alu_op = 2'b10; end
                K_RWB:   begin e.reg_write = 1; e.reg_dst = 1; end
                K_AEX:   begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
                K_AWB:   e.reg_write = 1;
                K_BR:    begin e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_write_cond = 1;
                               e.pc_source = 2'b01; end
                K_J:     begin e.pc_write = 1; e.pc_source = 2'b10; end
                default: ;
            endcase
            if (is_mem && !mem_ready && m_wait == TO) begin
                e.mem_err = 1; m_drain = 1'b1; m_idx = 0; m_wait = 0;
            end else if (is_mem && !mem_ready) begin
                m_wait++;
            end else begin
                m_wait = 0;
                if (m_idx >= 1 && m_idx == instr_len(m_op) - 1) begin
                    e.instr_done = 1;
                    if (instr_len(m_op) != 2) m_count = m_count + 32'd1;
                    m_idx = 0;
                end else begin
                    m_idx++;
                end
            end
        end
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL ctl_vector at t=%0t: got %b want %b", $time, act, e);
        end
        checks++;
        if (instr_count !== cnt_exp) begin
            errors++;
            $display("FAIL instr_count at t=%0t: got %0d want %0d", $time, instr_count, cnt_exp);
        end
    end

    task automatic step(input logic [5:0] op, input logic rdy, input logic rs);
        @(posedge clk);
        #1;
        opcode = op; mem_ready = rdy; arst = rs;
        @(negedge clk);
    endtask

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    initial begin
        step(6'h00, 0, 1);
        lit("reset_ctl", 32'(act), 32'd0);
        lit("reset_cnt", instr_count, 32'd0);
        step(6'h00, 1, 0);
        lit("boot_ctl", 32'(act), 32'd0);

        // R-type, zero wait
        step(6'h00, 1, 0);
        lit("r_fetch_pcw", 32'(pc_write), 32'd1);
        lit("r_fetch_irw", 32'(ir_write), 32'd1);
        repeat (3) step(6'h00, 1, 0);
        lit("r_done", 32'(instr_done), 32'd1);
        lit("r_regw", 32'(reg_write), 32'd1);
        lit("r_regdst", 32'(reg_dst), 32'd1);

        // BEQ then J
        repeat (3) step(6'h04, 1, 0);
        lit("beq_pwc", 32'(pc_write_cond), 32'd1);
        lit("beq_psrc", 32'(pc_source), 32'd1);
        repeat (3) step(6'h02, 1, 0);
        lit("j_pcw", 32'(pc_write), 32'd1);
        lit("j_psrc", 32'(pc_source), 32'd2);
        lit("j_cnt", instr_count, 32'd2);

        repeat (4) step(6'h08, 1, 0);
        lit("addi_done", 32'(instr_done), 32'd1);

        // LW with three wait cycles in MEM_READ: 8 cycles total
        repeat (3) step(6'h23, 1, 0);
        repeat (3) step(6'h23, 0, 0);
        step(6'h23, 1, 0);
        lit("lw_rd_last", 32'(mem_read), 32'd1);
        step(6'h23, 1, 0);
        lit("lw_m2r", 32'(mem_2_reg), 32'd1);
        lit("lw_done", 32'(instr_done), 32'd1);
        lit("lw_cnt_before", instr_count, 32'd4);

        repeat (4) step(6'h2B, 1, 0);
        lit("sw_memw", 32'(mem_write), 32'd1);
        lit("sw_done", 32'(instr_done), 32'd1);
        lit("sw_cnt_before", instr_count, 32'd5);

        // Unsupported opcode
        step(6'h3F, 1, 0);
        step(6'h3F, 1, 0);
        lit("ill_flag", 32'(illegal_op), 32'd1);
        lit("ill_done", 32'(instr_done), 32'd1);
        lit("ill_regw", 32'(reg_write), 32'd0);
        lit("ill_memw", 32'(mem_write), 32'd0);

        // FETCH stalls, then an R-type
        step(6'h00, 0, 0);
        lit("fetch_stall_rd", 32'(mem_read), 32'd1);
        lit("fetch_stall_pcw", 32'(pc_write), 32'd0);
        lit("ill_not_counted", instr_count, 32'd6);
        step(6'h00, 0, 0);
        repeat (4) step(6'h00, 1, 0);
        lit("r2_done", 32'(instr_done), 32'd1);

        // SW timeout
        repeat (3) step(6'h2B, 1, 0);
        for (int i = 0; i < TO; i++) step(6'h2B, 0, 0);
        lit("to_no_err_yet", 32'(mem_err), 32'd0);
        step(6'h2B, 0, 0);
        lit("to_err", 32'(mem_err), 32'd1);
        lit("to_not_done", 32'(instr_done), 32'd0);
        step(6'h2B, 1, 0);
        lit("to_drain_ctl", 32'(act), 32'd0);
        step(6'h00, 1, 0);
        lit("to_refetch", 32'(mem_read), 32'd1);
        lit("to_cnt", instr_count, 32'd7);
        repeat (3) step(6'h00, 1, 0);

        // mem_ready arriving on the timeout cycle completes the store
        repeat (3) step(6'h2B, 1, 0);
        for (int i = 0; i < TO; i++) step(6'h2B, 0, 0);
        step(6'h2B, 1, 0);
        lit("race_done", 32'(instr_done), 32'd1);
        lit("race_no_err", 32'(mem_err), 32'd0);

        // Reset in the middle of MEM_READ
        repeat (3) step(6'h23, 1, 0);
        step(6'h23, 0, 0);
        lit("pre_rst_cnt", instr_count, 32'd9);
        step(6'h23, 0, 1);
        lit("midrst_ctl", 32'(act), 32'd0);
        lit("midrst_cnt", instr_count, 32'd0);
        step(6'h00, 1, 0);
        lit("midrst_boot", 32'(act), 32'd0);
        step(6'h00, 1, 0);
        lit("midrst_fetch", 32'(mem_read), 32'd1);
        repeat (3) step(6'h00, 1, 0);
        step(6'h00, 1, 0);
        lit("post_rst_cnt", instr_count, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
